// File: rtl/maze_game_ctrl.sv
// maze_game_ctrl: game-flow sequencer for the 8x8 maze game.
// Owns the idle/load/settle/play/pause/win/lose/done state machine.
// It also drives the datapath soft reset, the map select, the
// level-held pause and the buzzer tone.
//
// Ports:
//   clk_in      in  1  system clock
//   rst         in  1  asynchronous active-high reset
//   start_pulse in  1  one-cycle start/next/restart request
//   pause_pulse in  1  one-cycle pause toggle
//   win_judge   in  1  level, player on exit cell
//   time_judge  in  1  level, countdown expired
//   bump_pulse  in  1  one-cycle pulse, move blocked by wall
//   game_rst    out 1  soft reset to the maze datapath
//   map_sel     out 1  maze select (0 = map 0, 1 = map 1)
//   pause       out 1  freezes moves and countdown when high
//   beep        out 1  buzzer square wave
//   state       out 3  current state code for debug LEDs
module maze_game_ctrl #(
    parameter int GRST_CYC       = 4,
    parameter int TONE_DIV       = 25000,
    parameter int BEEP_SHORT_CYC = 5000000,
    parameter int BEEP_LONG_CYC  = 50000000
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       start_pulse,
    input  logic       pause_pulse,
    input  logic       win_judge,
    input  logic       time_judge,
    input  logic       bump_pulse,
    output logic       game_rst,
    output logic       map_sel,
    output logic       pause,
    output logic       beep,
    output logic [2:0] state
);

    localparam int LW = (GRST_CYC > 2) ? $clog2(GRST_CYC) : 1;
    localparam int TW = (TONE_DIV > 2) ? $clog2(TONE_DIV) : 1;

    localparam logic [LW-1:0] LOAD_LAST = LW'(GRST_CYC - 1);
    localparam logic [TW-1:0] TONE_LAST = TW'(TONE_DIV - 1);
    localparam logic [31:0]   BT_SHORT  = 32'(BEEP_SHORT_CYC);
    localparam logic [31:0]   BT_LONG   = 32'(BEEP_LONG_CYC);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SETTLE = 3'd2,
        S_PLAY   = 3'd3,
        S_PAUSE  = 3'd4,
        S_WIN    = 3'd5,
        S_LOSE   = 3'd6,
        S_DONE   = 3'd7
    } state_t;

    state_t        state_q, state_d;
    logic          map_sel_q, map_sel_d;
    logic          pause_q, pause_d;
    logic          game_rst_q, game_rst_d;
    logic          beep_q, beep_d;
    logic [LW-1:0] load_cnt_q, load_cnt_d;
    logic [TW-1:0] tone_q, tone_d;
    logic [31:0]   bt_q, bt_d;

    logic load_entry;
    logic long_load;
    logic short_load;

    // State and registered-output flops
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            map_sel_q  <= 1'b0;
            pause_q    <= 1'b1;
            game_rst_q <= 1'b0;
            beep_q     <= 1'b0;
            load_cnt_q <= '0;
            tone_q     <= '0;
            bt_q       <= '0;
        end else begin
            state_q    <= state_d;
            map_sel_q  <= map_sel_d;
            pause_q    <= pause_d;
            game_rst_q <= game_rst_d;
            beep_q     <= beep_d;
            load_cnt_q <= load_cnt_d;
            tone_q     <= tone_d;
            bt_q       <= bt_d;
        end
    end

    // Next-state logic; judges and bumps only matter in PLAY
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_pulse)
                    state_d = S_LOAD;
            end
            S_LOAD: begin
                if (load_cnt_q == LOAD_LAST)
                    state_d = S_SETTLE;
            end
            S_SETTLE: begin
                state_d = S_PLAY;
            end
            S_PLAY: begin
                if (win_judge)
                    state_d = S_WIN;
                else if (time_judge)
                    state_d = S_LOSE;
                else if (pause_pulse)
                    state_d = S_PAUSE;
            end
            S_PAUSE: begin
                if (start_pulse)
                    state_d = S_LOAD;
                else if (pause_pulse)
                    state_d = S_PLAY;
            end
            S_WIN: begin
                if (start_pulse)
                    state_d = map_sel_q ? S_DONE : S_LOAD;
            end
            S_LOSE: begin
                if (start_pulse)
                    state_d = S_LOAD;
            end
            S_DONE: begin
                if (start_pulse)
                    state_d = S_LOAD;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output and timer next values, all derived from the next state
    // so the registered outputs line up with the state register.
    always_comb begin
        load_entry = (state_d == S_LOAD) && (state_q != S_LOAD);
        long_load  = (state_q == S_PLAY) &&
                     ((state_d == S_WIN) || (state_d == S_LOSE));
        short_load = (state_q == S_PLAY) && bump_pulse &&
                     (bt_q == '0);

        game_rst_d = (state_d == S_LOAD);
        pause_d    = (state_d != S_PLAY);

        map_sel_d = map_sel_q;
        if ((state_q == S_WIN) && start_pulse && !map_sel_q)
            map_sel_d = 1'b1;
        else if ((state_q == S_DONE) && start_pulse)
            map_sel_d = 1'b0;

        if ((state_q == S_LOAD) && (state_d == S_LOAD))
            load_cnt_d = load_cnt_q + 1'b1;
        else
            load_cnt_d = '0;

        bt_d   = bt_q;
        tone_d = tone_q;
        beep_d = beep_q;
        if (load_entry) begin
            bt_d   = '0;
            tone_d = '0;
            beep_d = 1'b0;
        end else if (long_load) begin
            // win/lose tone wins over any beep already running
            bt_d   = BT_LONG;
            tone_d = '0;
            beep_d = 1'b0;
        end else if (short_load) begin
            bt_d   = BT_SHORT;
            tone_d = '0;
            beep_d = 1'b0;
        end else if (bt_q != '0) begin
            bt_d = bt_q - 32'd1;
            if (bt_q == 32'd1) begin
                // window ends: leave the buzzer low
                tone_d = '0;
                beep_d = 1'b0;
            end else if (tone_q == TONE_LAST) begin
                tone_d = '0;
                beep_d = ~beep_q;
            end else begin
                tone_d = tone_q + 1'b1;
            end
        end else begin
            tone_d = '0;
            beep_d = 1'b0;
        end
    end

    assign state    = state_q;
    assign map_sel  = map_sel_q;
    assign pause    = pause_q;
    assign game_rst = game_rst_q;
    assign beep     = beep_q;

endmodule

// File: tb/tb_maze_game_ctrl.sv
// tb_maze_game_ctrl: scoreboard bench for maze_game_ctrl.
// Stimulus pushes cycle-stamped expectations; a monitor checks them.
module tb_maze_game_ctrl;

    localparam int GRST  = 4;
    localparam int DIV   = 2;
    localparam int SHORT = 8;
    localparam int LONG  = 32;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD   = 3'd1;
    localparam logic [2:0] SETTLE = 3'd2;
    localparam logic [2:0] PLAY   = 3'd3;
    localparam logic [2:0] PAUSE  = 3'd4;
    localparam logic [2:0] WIN    = 3'd5;
    localparam logic [2:0] LOSE   = 3'd6;
    localparam logic [2:0] DONE   = 3'd7;

    logic       clk_in = 1'b0;
    logic       rst = 1'b1;
    logic       start_pulse = 1'b0;
    logic       pause_pulse = 1'b0;
    logic       win_judge = 1'b0;
    logic       time_judge = 1'b0;
    logic       bump_pulse = 1'b0;
    logic       game_rst;
    logic       map_sel;
    logic       pause;
    logic       beep;
    logic [2:0] state;

    maze_game_ctrl #(
        .GRST_CYC      (GRST),
        .TONE_DIV      (DIV),
        .BEEP_SHORT_CYC(SHORT),
        .BEEP_LONG_CYC (LONG)
    ) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .start_pulse(start_pulse),
        .pause_pulse(pause_pulse),
        .win_judge  (win_judge),
        .time_judge (time_judge),
        .bump_pulse (bump_pulse),
        .game_rst   (game_rst),
        .map_sel    (map_sel),
        .pause      (pause),
        .beep       (beep),
        .state      (state)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) if (!rst) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [6:0] v;
        string      nm;
    } exp_t;

    exp_t sb[$];
    exp_t m;
    int   tests = 0;
    int   fails = 0;
    bit   drain_to = 1'b0;

    // Beep model: last timer load cycle and its window length
    int bl_start = 0;
    int bl_len   = 0;

    function automatic logic beep_model(int c);
        int d;
        d = c - bl_start;
        if (bl_len == 0 || d < 0 || d >= bl_len)
            return 1'b0;
        return ((d / DIV) % 2) == 1;
    endfunction

    task automatic exp1(int c, logic [2:0] st, logic gr,
                        logic ms, logic pz, string nm);
        exp_t e;
        e.cyc = c;
        e.v   = {st, gr, ms, pz, beep_model(c)};
        e.nm  = nm;
        sb.push_back(e);
    endtask

    task automatic expr(int c0, int c1, logic [2:0] st, logic gr,
                        logic ms, logic pz, string nm);
        for (int c = c0; c <= c1; c++)
            exp1(c, st, gr, ms, pz, nm);
    endtask

    // Start sampled after cycle p: LOAD, SETTLE, PLAY
    task automatic load_seq(int p, logic ms, string nm);
        bl_start = p + 1;
        bl_len   = 0;
        expr(p + 1, p + GRST, LOAD, 1'b1, ms, 1'b1, nm);
        exp1(p + GRST + 1, SETTLE, 1'b0, ms, 1'b1, nm);
        exp1(p + GRST + 2, PLAY, 1'b0, ms, 1'b0, nm);
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_cyc(int c);
        while (cyc < c) step();
    endtask

    // Monitor: compare every expectation due at this cycle
    always @(negedge clk_in) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            m = sb.pop_front();
            tests++;
            if (m.cyc < cyc) begin
                fails++;
                $display("FAIL %s cyc=%0d missed (now %0d)",
                         m.nm, m.cyc, cyc);
            end else if ({state, game_rst, map_sel, pause, beep}
                         !== m.v) begin
                fails++;
                $display("FAIL %s cyc=%0d got st/gr/ms/pz/bp=%b want %b",
                         m.nm, cyc,
                         {state, game_rst, map_sel, pause, beep}, m.v);
            end
        end
        if (drain_to && sb.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain %0d expectations left, got 0 want empty",
                     sb.size());
            sb.delete();
        end
    end

    initial begin
        exp1(0, IDLE, 1'b0, 1'b0, 1'b1, "reset");
        #22;
        rst = 1'b0;

        wait_cyc(5);
        expr(6, 10, IDLE, 1'b0, 1'b0, 1'b1, "idle");

        // Non-start inputs ignored in IDLE
        wait_cyc(7);
        pause_pulse = 1'b1; win_judge = 1'b1;
        time_judge = 1'b1;  bump_pulse = 1'b1;
        step();
        pause_pulse = 1'b0; win_judge = 1'b0;
        time_judge = 1'b0;  bump_pulse = 1'b0;

        // First start
        wait_cyc(10);
        start_pulse = 1'b1;
        load_seq(10, 1'b0, "start");
        step();
        start_pulse = 1'b0;

        // Bump beep, retrigger ignored 3 cycles later
        wait_cyc(20);
        bl_start = 21; bl_len = SHORT;
        expr(21, 30, PLAY, 1'b0, 1'b0, 1'b0, "bump");
        bump_pulse = 1'b1;
        step();
        bump_pulse = 1'b0;
        wait_cyc(23);
        bump_pulse = 1'b1;
        step();
        bump_pulse = 1'b0;

        // New bump after timer expired
        wait_cyc(31);
        bl_start = 32; bl_len = SHORT;
        expr(32, 41, PLAY, 1'b0, 1'b0, 1'b0, "bump3");
        bump_pulse = 1'b1;
        step();
        bump_pulse = 1'b0;

        // Win, lose and bump together: WIN with long beep
        wait_cyc(42);
        bl_start = 43; bl_len = LONG;
        expr(43, 79, WIN, 1'b0, 1'b0, 1'b1, "win1");
        win_judge = 1'b1; time_judge = 1'b1; bump_pulse = 1'b1;
        step();
        win_judge = 1'b0; time_judge = 1'b0; bump_pulse = 1'b0;

        // Next level on map 1
        wait_cyc(80);
        start_pulse = 1'b1;
        load_seq(80, 1'b1, "next");
        step();
        start_pulse = 1'b0;

        // Start ignored in PLAY
        wait_cyc(90);
        expr(91, 94, PLAY, 1'b0, 1'b1, 1'b0, "start_ign");
        start_pulse = 1'b1;
        step();
        start_pulse = 1'b0;

        // Pause and inputs ignored while paused
        wait_cyc(95);
        expr(96, 97, PAUSE, 1'b0, 1'b1, 1'b1, "pause");
        pause_pulse = 1'b1;
        step();
        pause_pulse = 1'b0;
        wait_cyc(97);
        expr(98, 99, PAUSE, 1'b0, 1'b1, 1'b1, "pause_ign");
        win_judge = 1'b1; time_judge = 1'b1; bump_pulse = 1'b1;
        step();
        win_judge = 1'b0; time_judge = 1'b0; bump_pulse = 1'b0;

        wait_cyc(100);
        exp1(101, PLAY, 1'b0, 1'b1, 1'b0, "resume");
        pause_pulse = 1'b1;
        step();
        pause_pulse = 1'b0;
        wait_cyc(102);
        exp1(103, PAUSE, 1'b0, 1'b1, 1'b1, "repause");
        pause_pulse = 1'b1;
        step();
        pause_pulse = 1'b0;

        // Start beats pause toggle in PAUSE, same map
        wait_cyc(104);
        start_pulse = 1'b1; pause_pulse = 1'b1;
        load_seq(104, 1'b1, "restart");
        step();
        start_pulse = 1'b0; pause_pulse = 1'b0;

        // Lose, then restart while the beep is running
        wait_cyc(112);
        bl_start = 113; bl_len = LONG;
        expr(113, 120, LOSE, 1'b0, 1'b1, 1'b1, "lose");
        time_judge = 1'b1;
        step();
        time_judge = 1'b0;
        wait_cyc(120);
        start_pulse = 1'b1;
        load_seq(120, 1'b1, "retry");
        step();
        start_pulse = 1'b0;

        // Second win goes to DONE
        wait_cyc(130);
        bl_start = 131; bl_len = LONG;
        expr(131, 134, WIN, 1'b0, 1'b1, 1'b1, "win2");
        win_judge = 1'b1;
        step();
        win_judge = 1'b0;
        wait_cyc(134);
        expr(135, 137, DONE, 1'b0, 1'b1, 1'b1, "done");
        start_pulse = 1'b1;
        step();
        start_pulse = 1'b0;

        // DONE start returns to map 0
        wait_cyc(138);
        start_pulse = 1'b1;
        load_seq(138, 1'b0, "replay");
        step();
        start_pulse = 1'b0;

        // Win then load map 1, reset on 2nd game_rst cycle
        wait_cyc(146);
        bl_start = 147; bl_len = LONG;
        exp1(147, WIN, 1'b0, 1'b0, 1'b1, "win3");
        win_judge = 1'b1;
        step();
        win_judge = 1'b0;
        wait_cyc(149);
        bl_start = 150; bl_len = 0;
        exp1(150, LOAD, 1'b1, 1'b1, 1'b1, "load_pre_rst");
        start_pulse = 1'b1;
        step();
        start_pulse = 1'b0;
        wait_cyc(151);
        rst = 1'b1;
        exp1(151, IDLE, 1'b0, 1'b0, 1'b1, "rst_async");
        #6;
        rst = 1'b0;
        expr(152, 155, IDLE, 1'b0, 1'b0, 1'b1, "post_rst");

        wait_cyc(156);
        for (int i = 0; i < 20 && sb.size() > 0; i++) step();
        if (sb.size() > 0) begin
            drain_to = 1'b1;
            @(negedge clk_in);
            #1;
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/maze_game_ctrl.md
# maze_game_ctrl

Top-level game sequencer for the 8x8 maze game. It owns the game-flow state machine (idle, load, play, pause, win, lose, done) and drives a soft reset pulse into the maze datapath. It also selects the map, produces the level-held `pause` for the move, countdown and display logic, and generates the buzzer tone. It sits between the debounced front-panel buttons and the existing direction, timer and LED-matrix blocks, replacing the raw `map`/`pause` switches.

## Interface
- `GRST_CYC`, 4: number of cycles `game_rst` is held high per load.
- `TONE_DIV`, 25000: half-period of the buzzer square wave in `clk_in` cycles (1 kHz at 50 MHz).
- `BEEP_SHORT_CYC`, 5000000: duration of the wall-bump beep (100 ms).
- `BEEP_LONG_CYC`, 50000000: duration of the win/lose beep (1 s).

Ports:
- `clk_in` in 1: system clock, 50 MHz.
- `rst` in 1: reset, asynchronous, active-high.
- `start_pulse` in 1: one-cycle debounced start/next/restart request.
- `pause_pulse` in 1: one-cycle debounced pause toggle.
- `win_judge` in 1: level, player on exit cell.
- `time_judge` in 1: level, countdown expired.
- `bump_pulse` in 1: one-cycle pulse, move blocked by wall.
- `game_rst` out 1: active-high soft reset to datapath; top ORs it with `rst`.
- `map_sel` out 1: maze select, 0 = map 0, 1 = map 1.
- `pause` out 1: 1 freezes moves and countdown.
- `beep` out 1: buzzer drive.
- `state` out 3: current state code, for debug LEDs.

## Operation
- All inputs are synchronous to `clk_in`.
- All outputs are registered (Moore).
- State codes: IDLE=0, LOAD=1, SETTLE=2, PLAY=3, PAUSE=4, WIN=5, LOSE=6, DONE=7.

Reset values:
- `state` = IDLE, `map_sel` = 0, `pause` = 1, `game_rst` = 0, `beep` = 0.
- Beep timer, tone counter and load counter are all cleared.

Per-state behaviour and transitions:
- **IDLE**: `pause` = 1. `start_pulse` → LOAD.
- **LOAD**: `game_rst` = 1 and `pause` = 1 for exactly `GRST_CYC` cycles, then → SETTLE.
- **SETTLE**: one cycle with `game_rst` = 0 and `pause` = 1, so the registered `win_judge`/`time_judge` clear; then → PLAY.
- **PLAY**: `pause` = 0.
  - `win_judge` → WIN.
  - else `time_judge` → LOSE.
  - else `pause_pulse` → PAUSE.
  - `start_pulse` is ignored.
- **PAUSE**: `pause` = 1.
  - `start_pulse` → LOAD, restarting the same map; it has priority over `pause_pulse`.
  - else `pause_pulse` → PLAY.
- **WIN**: `pause` = 1. `start_pulse` with `map_sel` = 0 sets `map_sel` to 1 and → LOAD; with `map_sel` = 1 → DONE.
- **LOSE**: `pause` = 1. `start_pulse` → LOAD with the same `map_sel`.
- **DONE**: `pause` = 1. `start_pulse` clears `map_sel` to 0 and → LOAD.

Input qualification:
- `win_judge`, `time_judge` and `bump_pulse` are ignored outside PLAY.
- `pause_pulse` is ignored outside PLAY and PAUSE.

Beep generator:
- 32-bit down-timer `bt`; `beep` toggles every `TONE_DIV` cycles while `bt` ≠ 0, and is 0 when `bt` = 0.
- The tone counter restarts on every timer load.
- Entering WIN or LOSE loads `BEEP_LONG_CYC`, overriding any running beep.
- `bump_pulse` in PLAY loads `BEEP_SHORT_CYC` only when `bt` = 0, so a running beep is not retriggered.
- Any entry to LOAD clears `bt` and forces `beep` = 0.

## Timing
- A `start_pulse` sampled at edge N gives `state` = LOAD and `game_rst` = 1 from edge N+1.
- `game_rst` falls at edge N+1+`GRST_CYC`; `state` = PLAY and `pause` = 0 at edge N+2+`GRST_CYC`.
- `map_sel` changes at the same edge LOAD is entered and is stable throughout LOAD.
- PLAY → WIN/LOSE/PAUSE: `pause` rises one edge after the qualifying input is sampled.
- Beep: `beep` first rises `TONE_DIV` cycles after a timer load and is 0 once `bt` reaches 0.
- Same-cycle priority: WIN over LOSE over pause. A long beep load overrides a simultaneous bump.
- `rst` asserted in any state returns all outputs to reset values immediately (asynchronous), including mid-LOAD with `game_rst` high.

## Test plan
Benches override parameters: `GRST_CYC`=4, `TONE_DIV`=2, `BEEP_SHORT_CYC`=8, `BEEP_LONG_CYC`=32.

- **Start**: reset, then `start_pulse` at cycle 10 → `game_rst` high on cycles 11–14, SETTLE at 15, PLAY with `pause` = 0 at 16, `map_sel` = 0.
- **Level flow**:
  - `win_judge` in PLAY → WIN, `pause` = 1, `beep` toggles every 2 cycles for 32 cycles.
  - `start_pulse` → `map_sel` = 1, LOAD.
  - Second win plus `start_pulse` → DONE.
  - `start_pulse` → `map_sel` = 0, LOAD.
- **Simultaneous events**: `win_judge` and `time_judge` rise in the same PLAY cycle → WIN, not LOSE. `bump_pulse` in that same cycle → 32-cycle beep, not 8.
- **Pause**:
  - `pause_pulse` in PLAY → PAUSE, and `bump_pulse`/`win_judge` are then ignored.
  - `start_pulse` and `pause_pulse` in the same cycle in PAUSE → LOAD with the same `map_sel`.
- **Bump beep**: two `bump_pulse` 3 cycles apart in PLAY → a single 8-cycle beep window, no retrigger; a third bump after `bt` = 0 → a new 8-cycle beep.
- **Reset mid-load**: assert `rst` at the 2nd `game_rst` cycle → `game_rst`, `beep` = 0, `pause` = 1, `state` = IDLE, `map_sel` = 0 immediately.
